// File: rtl/dplca_txop_select.sv
// ============================================================================
// dplca_txop_select
// ----------------------------------------------------------------------------
// DPLCA local TXOP-ID selector. After every aging epoch it walks the TXOP
// claim table kept by the aging machine, claims the first unclaimed ID in
// 1..max_id as the local node ID, and holds it until a duplicate transmitter
// is reported or the ID drops out of range.
//
// Optional feature macro: DPLCA_SCAN_ROTATE_EN
//   defined   : each scan starts just after the last claimed ID (wrapped into
//               1..max_id), spreading re-selection after a duplicate.
//   undefined : each scan starts at ID 1 (lowest free ID wins).
//
// Ports
//   clk                        in   block clock
//   reset                      in   asynchronous, active-high reset
//   dplca_en                   in   DPLCA enable (level); 0 forces DISABLED
//   dplca_new_age              in   pulse: aging epoch complete, start a scan
//   dplca_txop_table_upd       in   pulse: table changed, restart a running scan
//   dplca_dup_det              in   pulse: another node used our TXOP
//   max_id                     in   highest TXOP ID eligible for selection
//   txop_claim_table_unpacked  in   flattened table, entry i at [2i+1:2i]
//   sel_state                  out  DISABLED=0 IDLE=1 SCAN=2 CLAIM=3 HELD=4
//   scan_idx                   out  table index being examined
//   dplca_local_id             out  selected TXOP ID
//   dplca_id_valid             out  dplca_local_id is owned by this node
//   dplca_table_full           out  last scan found no free ID in 1..max_id
//
// Handshake: there is no valid/ready pair; all inputs are single-cycle pulses
// or levels sampled on the rising clock edge, and every output is a flop.
// ============================================================================
module dplca_txop_select #(
    parameter int          ID_W      = 8,
    parameter int          NUM_IDS   = 256,
    parameter logic [1:0]  UNCLAIMED = 2'b00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dplca_en,
    input  logic                   dplca_new_age,
    input  logic                   dplca_txop_table_upd,
    input  logic                   dplca_dup_det,
    input  logic [ID_W-1:0]        max_id,
    input  logic [2*NUM_IDS-1:0]   txop_claim_table_unpacked,
    output logic [2:0]             sel_state,
    output logic [ID_W-1:0]        scan_idx,
    output logic [ID_W-1:0]        dplca_local_id,
    output logic                   dplca_id_valid,
    output logic                   dplca_table_full
);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SCAN     = 3'd2,
        ST_CLAIM    = 3'd3,
        ST_HELD     = 3'd4
    } sel_state_e;

    // One extra bit so max_id = 2^ID_W-1 can be counted to without wrapping.
    localparam int CNT_W = ID_W + 1;
    localparam logic [ID_W-1:0]  ONE_ID  = 1;
    localparam logic [CNT_W-1:0] ONE_CNT = 1;

    sel_state_e        state_q, state_d;
    logic [ID_W-1:0]   scan_idx_q, scan_idx_d;
    logic [ID_W-1:0]   local_id_q, local_id_d;
    logic              id_valid_q, id_valid_d;
    logic              table_full_q, table_full_d;
    logic [CNT_W-1:0]  visit_cnt_q, visit_cnt_d;

    logic [ID_W-1:0]   start_idx;
    logic [ID_W-1:0]   next_idx;
    logic [CNT_W-1:0]  visit_inc;
    logic [1:0]        cur_entry;
    logic              entry_free;

    // Scan origin.
    always_comb begin
`ifdef DPLCA_SCAN_ROTATE_EN
        // local_id is zero until the first claim, which also maps to 1.
        if (local_id_q == '0 || local_id_q >= max_id) begin
            start_idx = ONE_ID;
        end else begin
            start_idx = local_id_q + ONE_ID;
        end
`else
        start_idx = ONE_ID;
`endif
    end

    // Wrap back to 1 (never 0, the coordinator) past max_id; this also
    // covers the 8-bit 255 -> 1 wrap.
    always_comb begin
        if (scan_idx_q >= max_id) begin
            next_idx = ONE_ID;
        end else begin
            next_idx = scan_idx_q + ONE_ID;
        end
    end

    assign visit_inc  = visit_cnt_q + ONE_CNT;
    // The table is read live at scan_idx; no snapshot is taken.
    assign cur_entry  = txop_claim_table_unpacked[{scan_idx_q, 1'b0} +: 2];
    assign entry_free = (cur_entry == UNCLAIMED) && (scan_idx_q != '0);

    always_comb begin
        state_d      = state_q;
        scan_idx_d   = scan_idx_q;
        local_id_d   = local_id_q;
        id_valid_d   = id_valid_q;
        table_full_d = table_full_q;
        visit_cnt_d  = visit_cnt_q;

        if (!dplca_en) begin
            state_d      = ST_DISABLED;
            scan_idx_d   = '0;
            local_id_d   = '0;
            id_valid_d   = 1'b0;
            table_full_d = 1'b0;
            visit_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    // A table_upd in the same cycle is irrelevant: the scan
                    // has not started yet.
                    if (dplca_new_age) begin
                        if (max_id == '0) begin
                            table_full_d = 1'b1;
                        end else begin
                            state_d      = ST_SCAN;
                            scan_idx_d   = start_idx;
                            visit_cnt_d  = '0;
                            table_full_d = 1'b0;
                        end
                    end
                end
                ST_SCAN: begin
                    if (dplca_txop_table_upd) begin
                        // Entry read this cycle may be stale: drop it, restart.
                        scan_idx_d  = start_idx;
                        visit_cnt_d = '0;
                    end else if (entry_free) begin
                        state_d    = ST_CLAIM;
                        local_id_d = scan_idx_q;
                    end else if (visit_inc >= {1'b0, max_id}) begin
                        state_d      = ST_IDLE;
                        table_full_d = 1'b1;
                    end else begin
                        scan_idx_d  = next_idx;
                        visit_cnt_d = visit_inc;
                    end
                end
                ST_CLAIM: begin
                    state_d    = ST_HELD;
                    id_valid_d = 1'b1;
                end
                ST_HELD: begin
                    // new_age is deliberately ignored while holding an ID.
                    if (dplca_dup_det || (max_id < local_id_q)) begin
                        state_d    = ST_IDLE;
                        id_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_DISABLED;
            scan_idx_q   <= '0;
            local_id_q   <= '0;
            id_valid_q   <= 1'b0;
            table_full_q <= 1'b0;
            visit_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            scan_idx_q   <= scan_idx_d;
            local_id_q   <= local_id_d;
            id_valid_q   <= id_valid_d;
            table_full_q <= table_full_d;
            visit_cnt_q  <= visit_cnt_d;
        end
    end

    assign sel_state        = state_q;
    assign scan_idx         = scan_idx_q;
    assign dplca_local_id   = local_id_q;
    assign dplca_id_valid   = id_valid_q;
    assign dplca_table_full = table_full_q;

endmodule

// File: tb/tb_dplca_txop_select.sv
// ============================================================================
// tb_dplca_txop_select
// Bench for dplca_txop_select: a vector table of scan scenarios driven through
// a scoreboard queue, followed by hand-written multi-cycle sequences.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ============================================================================
module tb_dplca_txop_select;

    localparam int ST_DISABLED = 0;
    localparam int ST_IDLE     = 1;
    localparam int ST_SCAN     = 2;
    localparam int ST_HELD     = 4;
    localparam int MAX_WAIT    = 600;
    localparam int EXP_W       = 22;   // {valid, id[7:0], full, lat[11:0]}

    logic         clk;
    logic         reset;
    logic         dplca_en;
    logic         dplca_new_age;
    logic         dplca_txop_table_upd;
    logic         dplca_dup_det;
    logic [7:0]   max_id;
    logic [511:0] txop_claim_table_unpacked;
    logic [2:0]   sel_state;
    logic [7:0]   scan_idx;
    logic [7:0]   dplca_local_id;
    logic         dplca_id_valid;
    logic         dplca_table_full;

    int n_checks = 0;
    int n_pass   = 0;

    logic [EXP_W-1:0] exp_q[$];

    typedef struct {
        logic [7:0]  max_id;
        logic [15:0] free_lo;   // free flags for IDs 0..15
        logic [7:0]  free_hi;   // one extra free ID (0 = none)
        logic        exp_valid;
        logic [7:0]  exp_id;
        logic        exp_full;
        int          exp_lat;   // edges after the new_age edge until done
    } vec_t;

    vec_t vecs[11];

    dplca_txop_select dut (
        .clk                       (clk),
        .reset                     (reset),
        .dplca_en                  (dplca_en),
        .dplca_new_age             (dplca_new_age),
        .dplca_txop_table_upd      (dplca_txop_table_upd),
        .dplca_dup_det             (dplca_dup_det),
        .max_id                    (max_id),
        .txop_claim_table_unpacked (txop_claim_table_unpacked),
        .sel_state                 (sel_state),
        .scan_idx                  (scan_idx),
        .dplca_local_id            (dplca_local_id),
        .dplca_id_valid            (dplca_id_valid),
        .dplca_table_full          (dplca_table_full)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Claimed entries get a rotating non-zero code so every taken code is used.
    function automatic logic [511:0] mk_table(input logic [15:0] free_lo,
                                              input logic [7:0]  free_hi);
        logic [511:0] t;
        logic         fr;
        logic [1:0]   code;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            fr = (i < 16) ? free_lo[i] : 1'b0;
            if (free_hi != 8'd0 && i == int'(free_hi)) fr = 1'b1;
            code = 2'((i % 3) + 1);
            t[2*i +: 2] = fr ? 2'b00 : code;
        end
        return t;
    endfunction

    // Disable then re-enable: lands in IDLE with outputs cleared.
    task automatic go_idle();
        dplca_en = 1'b0;
        tick();
        dplca_en = 1'b1;
        tick();
    endtask

    // Pulse new_age, push the expected outcome, wait for the DUT to settle in
    // HELD or IDLE, then pop and compare.
    task automatic run_scan(input string tag, input logic exp_valid,
                            input logic [7:0] exp_id, input logic exp_full,
                            input int exp_lat, input logic chk_lat);
        int lat;
        logic [EXP_W-1:0] e;
        exp_q.push_back({exp_valid, exp_id, exp_full, 12'(exp_lat)});
        dplca_new_age = 1'b1;
        tick();
        dplca_new_age = 1'b0;
        lat = 0;
        while (!(int'(sel_state) == ST_HELD || int'(sel_state) == ST_IDLE)
               && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
        check({tag, " timeout"}, int'(lat < MAX_WAIT), 1);
        e = exp_q.pop_front();
        check({tag, " valid"}, int'(dplca_id_valid), int'(e[21]));
        check({tag, " local_id"}, int'(dplca_local_id), int'(e[20:13]));
        check({tag, " table_full"}, int'(dplca_table_full), int'(e[12]));
        check({tag, " state"}, int'(sel_state), e[21] ? ST_HELD : ST_IDLE);
        if (chk_lat) check({tag, " latency"}, lat, int'(e[11:0]));
    endtask

    // ---------------- test ----------------
    initial begin
        // max, free_lo, free_hi, valid, id, full, lat
        vecs[0]  = '{8'd8,   16'hFFF0, 8'd0,   1'b1, 8'd4,   1'b0, 5};
        vecs[1]  = '{8'd8,   16'h0000, 8'd0,   1'b0, 8'd0,   1'b1, 8};
        vecs[2]  = '{8'd8,   16'h0001, 8'd0,   1'b0, 8'd0,   1'b1, 8};
        vecs[3]  = '{8'd8,   16'h0002, 8'd0,   1'b1, 8'd1,   1'b0, 2};
        vecs[4]  = '{8'd8,   16'h0200, 8'd0,   1'b0, 8'd0,   1'b1, 8};
        vecs[5]  = '{8'd8,   16'h0100, 8'd0,   1'b1, 8'd8,   1'b0, 9};
        vecs[6]  = '{8'd1,   16'h0000, 8'd0,   1'b0, 8'd0,   1'b1, 1};
        vecs[7]  = '{8'd255, 16'h0000, 8'd255, 1'b1, 8'd255, 1'b0, 256};
        vecs[8]  = '{8'd255, 16'h0000, 8'd0,   1'b0, 8'd0,   1'b1, 255};
        vecs[9]  = '{8'd0,   16'hFFFF, 8'd0,   1'b0, 8'd0,   1'b1, 0};
        vecs[10] = '{8'd200, 16'h0000, 8'd150, 1'b1, 8'd150, 1'b0, 151};

        reset = 1'b1;
        dplca_en = 1'b0;
        dplca_new_age = 1'b0;
        dplca_txop_table_upd = 1'b0;
        dplca_dup_det = 1'b0;
        max_id = 8'd8;
        txop_claim_table_unpacked = '0;
        #1;
        check("reset state", int'(sel_state), ST_DISABLED);
        check("reset scan_idx", int'(scan_idx), 0);
        check("reset local_id", int'(dplca_local_id), 0);
        check("reset valid", int'(dplca_id_valid), 0);
        check("reset full", int'(dplca_table_full), 0);
        tick();
        tick();
        reset = 1'b0;
        dplca_en = 1'b1;
        tick();
        check("enable -> idle", int'(sel_state), ST_IDLE);

        // ---- table-driven scans ----
        foreach (vecs[i]) begin
            go_idle();
            max_id = vecs[i].max_id;
            txop_claim_table_unpacked = mk_table(vecs[i].free_lo, vecs[i].free_hi);
            run_scan($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_id,
                     vecs[i].exp_full, vecs[i].exp_lat, 1'b1);
        end

        // ---- HELD: new_age ignored, dup+new_age, rescan, range drop ----
        go_idle();
        max_id = 8'd8;
        txop_claim_table_unpacked = mk_table(16'hFFF0, 8'd0);
        run_scan("held setup", 1'b1, 8'd4, 1'b0, 5, 1'b1);
        dplca_new_age = 1'b1;
        tick();
        dplca_new_age = 1'b0;
        tick();
        check("held ignores new_age", int'(sel_state), ST_HELD);
        dplca_dup_det = 1'b1;
        dplca_new_age = 1'b1;
        tick();
        dplca_dup_det = 1'b0;
        dplca_new_age = 1'b0;
        check("dup state", int'(sel_state), ST_IDLE);
        check("dup valid", int'(dplca_id_valid), 0);
        check("dup keeps id", int'(dplca_local_id), 4);
        txop_claim_table_unpacked = mk_table(16'hFFE0, 8'd0);
        run_scan("rescan", 1'b1, 8'd5, 1'b0, 0, 1'b0);
        max_id = 8'd4;
        tick();
        check("range drop state", int'(sel_state), ST_IDLE);
        check("range drop valid", int'(dplca_id_valid), 0);
        check("range drop id", int'(dplca_local_id), 5);
        max_id = 8'd8;

        // ---- table_upd mid-scan restarts at 1; new_age+upd in IDLE ----
        go_idle();
        txop_claim_table_unpacked = mk_table(16'h0040, 8'd0);
        dplca_new_age = 1'b1;
        dplca_txop_table_upd = 1'b1;
        tick();
        dplca_new_age = 1'b0;
        dplca_txop_table_upd = 1'b0;
        check("new_age+upd -> scan", int'(sel_state), ST_SCAN);
        check("scan start idx", int'(scan_idx), 1);
        tick();
        tick();
        check("mid-scan idx", int'(scan_idx), 3);
        txop_claim_table_unpacked = mk_table(16'h0044, 8'd0);
        dplca_txop_table_upd = 1'b1;
        tick();
        dplca_txop_table_upd = 1'b0;
        check("upd restart idx", int'(scan_idx), 1);
        tick();
        tick();
        tick();
        check("upd select valid", int'(dplca_id_valid), 1);
        check("upd select id", int'(dplca_local_id), 2);

        // ---- en drop mid-scan ----
        go_idle();
        txop_claim_table_unpacked = mk_table(16'h0000, 8'd0);
        dplca_new_age = 1'b1;
        tick();
        dplca_new_age = 1'b0;
        tick();
        dplca_en = 1'b0;
        tick();
        check("en drop state", int'(sel_state), ST_DISABLED);
        check("en drop scan_idx", int'(scan_idx), 0);
        check("en drop full", int'(dplca_table_full), 0);
        dplca_en = 1'b1;
        tick();

        // ---- asynchronous reset while HELD ----
        txop_claim_table_unpacked = mk_table(16'h0008, 8'd0);
        run_scan("pre-reset", 1'b1, 8'd3, 1'b0, 4, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("async reset state", int'(sel_state), ST_DISABLED);
        check("async reset valid", int'(dplca_id_valid), 0);
        check("async reset id", int'(dplca_local_id), 0);
        tick();
        reset = 1'b0;
        tick();
        check("post reset idle", int'(sel_state), ST_IDLE);

`ifdef DPLCA_SCAN_ROTATE_EN
        // ---- rotating start after a duplicate ----
        go_idle();
        txop_claim_table_unpacked = mk_table(16'h0080, 8'd0);
        run_scan("rot setup", 1'b1, 8'd7, 1'b0, 8, 1'b1);
        max_id = 8'd7;
        txop_claim_table_unpacked = mk_table(16'h0004, 8'd0);
        dplca_dup_det = 1'b1;
        tick();
        dplca_dup_det = 1'b0;
        run_scan("rot wrap", 1'b1, 8'd2, 1'b0, 3, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
